race_sequencer: RTL and testbench

Controller that runs one full challenge/response cycle of the delay-based PUF. On `start` it latches a base challenge and runs `RESP_BITS` sequential races. For each race it holds the arbiter, scrambler and counter in reset, presents a per-bit challenge, releases the race, and waits for the arbiter's asynchronous `bit_done`. Captured bits are assembled into a response word, which is handed to the host interface with a valid/ack handshake; a per-race timeout guards against a hung arbiter.

---
 rtl/race_sequencer_pkg.sv | 22 ++
 rtl/race_sequencer_if.sv | 30 +++
 rtl/race_sequencer_sync_edge.sv | 40 ++++
 rtl/race_sequencer.sv | 159 +++++++++++++++
 tb/tb_race_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/race_sequencer_pkg.sv
// Shared types and default sizing for the PUF race sequencer.
// Default parameter constants plus a small helper used to size shared counters.
package puf_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_RACE,
      ST_CAPTURE,
      ST_DONE
   } seq_state_t;

   localparam int DEF_RESP_BITS = 8;
   localparam int DEF_CHAL_W    = 8;
   localparam int DEF_SETTLE    = 3;
   localparam int DEF_TIMEOUT   = 1023;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/race_sequencer_if.sv
// Host-side request/response bundle of the race sequencer.
// The host (master) issues start/challenge and acknowledges the response word.
interface race_sequencer_if
   import puf_seq_pkg::*;
#(
   parameter int RESP_BITS = DEF_RESP_BITS,
   parameter int CHAL_W    = DEF_CHAL_W
);
   localparam int IDX_W = $clog2(RESP_BITS + 1);

   logic                 start;
   logic [CHAL_W-1:0]    challenge_in;
   logic                 host_ack;
   logic                 busy;
   logic [IDX_W-1:0]     bit_index;
   logic [RESP_BITS-1:0] response;
   logic                 resp_valid;
   logic                 timeout_err;

   modport master (
      output start, challenge_in, host_ack,
      input  busy, bit_index, response, resp_valid, timeout_err
   );

   modport slave (
      input  start, challenge_in, host_ack,
      output busy, bit_index, response, resp_valid, timeout_err
   );

endinterface

// File: rtl/race_sequencer_sync_edge.sv
// Two-flop synchronizer for an asynchronous input with a registered rising-edge pulse.
// level follows the input two edges later; rise pulses one edge after level rises.
module sync_edge (
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic level,
   output logic rise
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;
   logic rise_q, rise_d;

   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
      prev_d = sync_q;
      rise_d = sync_q & ~prev_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
      end
   end

   assign level = sync_q;
   assign rise  = rise_q;

endmodule

// File: rtl/race_sequencer.sv
// Runs RESP_BITS arbiter races per start, shifting each captured bit into the response word.
// A race that never reports bit_done is closed after TIMEOUT cycles with bit 0 and a sticky error.
module race_sequencer
   import puf_seq_pkg::*;
#(
   parameter int RESP_BITS = DEF_RESP_BITS,
   parameter int CHAL_W    = DEF_CHAL_W,
   parameter int SETTLE    = DEF_SETTLE,
   parameter int TIMEOUT   = DEF_TIMEOUT
) (
   input  logic              clock,
   input  logic              reset,
   race_sequencer_if.slave   host,
   input  logic              bit_done,
   input  logic              bit_in,
   output logic [CHAL_W-1:0] challenge_out,
   output logic              race_reset,
   output logic              race_go
);

   localparam int IDX_W = $clog2(RESP_BITS + 1);
   localparam int CNT_W = $clog2(max_int(SETTLE, TIMEOUT) + 1);

   seq_state_t           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     bit_index_q, bit_index_d;
   logic [RESP_BITS-1:0] response_q, response_d;
   logic [CHAL_W-1:0]    chal_base_q, chal_base_d;
   logic [CHAL_W-1:0]    challenge_out_q, challenge_out_d;
   logic                 race_bit_q, race_bit_d;
   logic                 timeout_err_q, timeout_err_d;
   logic                 race_reset_q, race_reset_d;
   logic                 race_go_q, race_go_d;
   logic                 busy_q, busy_d;
   logic                 resp_valid_q, resp_valid_d;

   logic done_rise, done_level_unused;
   logic bit_sync, bit_rise_unused;

   sync_edge u_done_sync (
      .clock    (clock),
      .reset    (reset),
      .async_in (bit_done),
      .level    (done_level_unused),
      .rise     (done_rise)
   );

   sync_edge u_bit_sync (
      .clock    (clock),
      .reset    (reset),
      .async_in (bit_in),
      .level    (bit_sync),
      .rise     (bit_rise_unused)
   );

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      bit_index_d     = bit_index_q;
      response_d      = response_q;
      chal_base_d     = chal_base_q;
      challenge_out_d = challenge_out_q;
      race_bit_d      = race_bit_q;
      timeout_err_d   = timeout_err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (host.start) begin
               chal_base_d     = host.challenge_in;
               challenge_out_d = host.challenge_in;
               response_d      = '0;
               bit_index_d     = '0;
               timeout_err_d   = 1'b0;
               cnt_d           = CNT_W'(1);
               state_d         = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE)) begin
               cnt_d   = CNT_W'(1);
               state_d = ST_RACE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RACE: begin
            // A real edge beats an expiring timeout in the same cycle.
            if (done_rise) begin
               race_bit_d = bit_sync;
               state_d    = ST_CAPTURE;
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               race_bit_d    = 1'b0;
               timeout_err_d = 1'b1;
               state_d       = ST_CAPTURE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_CAPTURE: begin
            response_d      = RESP_BITS'({response_q, race_bit_q});
            bit_index_d     = bit_index_q + 1'b1;
            challenge_out_d = chal_base_q + CHAL_W'(bit_index_d);
            cnt_d           = CNT_W'(1);
            state_d         = (bit_index_q == IDX_W'(RESP_BITS - 1)) ? ST_DONE : ST_SETTLE;
         end
         ST_DONE: begin
            if (host.host_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      race_reset_d = (state_d != ST_RACE);
      race_go_d    = (state_d == ST_RACE);
      busy_d       = (state_d != ST_IDLE);
      resp_valid_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         bit_index_q     <= '0;
         response_q      <= '0;
         chal_base_q     <= '0;
         challenge_out_q <= '0;
         race_bit_q      <= 1'b0;
         timeout_err_q   <= 1'b0;
         race_reset_q    <= 1'b1;
         race_go_q       <= 1'b0;
         busy_q          <= 1'b0;
         resp_valid_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         bit_index_q     <= bit_index_d;
         response_q      <= response_d;
         chal_base_q     <= chal_base_d;
         challenge_out_q <= challenge_out_d;
         race_bit_q      <= race_bit_d;
         timeout_err_q   <= timeout_err_d;
         race_reset_q    <= race_reset_d;
         race_go_q       <= race_go_d;
         busy_q          <= busy_d;
         resp_valid_q    <= resp_valid_d;
      end
   end

   assign challenge_out    = challenge_out_q;
   assign race_reset       = race_reset_q;
   assign race_go          = race_go_q;
   assign host.busy        = busy_q;
   assign host.bit_index   = bit_index_q;
   assign host.response    = response_q;
   assign host.resp_valid  = resp_valid_q;
   assign host.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_race_sequencer.sv
// Scoreboard bench for race_sequencer: a behavioural arbiter answers each race,
// expected challenges/responses are queued by the driver and popped by a monitor.
module tb_race_sequencer;
   import puf_seq_pkg::*;

   localparam int RESP_BITS = 8;
   localparam int CHAL_W    = 8;
   localparam int SETTLE    = 3;
   localparam int TIMEOUT   = 1023;
   localparam int NOM_LAT   = 2;
   localparam int WAIT_MAX  = RESP_BITS * (TIMEOUT + 20) + 200;

   typedef struct {
      logic [7:0] resp;
      logic       err;
   } exp_t;
   typedef logic [7:0] chal_tab_t [8];

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       bit_done;
   logic       bit_in;
   logic [7:0] challenge_out;
   logic       race_reset;
   logic       race_go;

   int checks = 0;
   int errors = 0;

   exp_t       resp_q[$];
   logic [7:0] chal_q[$];

   logic [7:0] arb_bits    = 8'h00;
   int         silent_race = -1;
   int         arb_lat[8];
   int         len_check_idx = -1;
   int         spur_cycles   = 0;

   race_sequencer_if #(.RESP_BITS(RESP_BITS), .CHAL_W(CHAL_W)) hif ();

   race_sequencer #(
      .RESP_BITS (RESP_BITS),
      .CHAL_W    (CHAL_W),
      .SETTLE    (SETTLE),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .host          (hif),
      .bit_done      (bit_done),
      .bit_in        (bit_in),
      .challenge_out (challenge_out),
      .race_reset    (race_reset),
      .race_go       (race_go)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic setup_arb(input logic [7:0] bits, input int silent, input int slow_idx,
                            input int slow_lat);
      arb_bits    = bits;
      silent_race = silent;
      for (int i = 0; i < 8; i++) arb_lat[i] = NOM_LAT;
      if (slow_idx >= 0) arb_lat[slow_idx] = slow_lat;
   endtask

   task automatic push_chal_tab(input chal_tab_t t);
      for (int i = 0; i < 8; i++) chal_q.push_back(t[i]);
   endtask

   task automatic push_chal_base(input logic [7:0] base);
      for (int i = 0; i < 8; i++) chal_q.push_back(base + 8'(i));
   endtask

   task automatic start_response(input logic [7:0] chal);
      hif.challenge_in = chal;
      hif.start        = 1'b1;
      tick(1);
      hif.start        = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!hif.resp_valid && n < WAIT_MAX) begin
         tick(1);
         n++;
      end
      check(name, hif.resp_valid, 1'b1);
   endtask

   task automatic ack();
      hif.host_ack = 1'b1;
      tick(1);
      hif.host_ack = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_race_reset"}, race_reset, 1'b1);
      check({tag, "_race_go"}, race_go, 1'b0);
      check({tag, "_busy"}, hif.busy, 1'b0);
      check({tag, "_resp_valid"}, hif.resp_valid, 1'b0);
      check({tag, "_timeout_err"}, hif.timeout_err, 1'b0);
      check({tag, "_bit_index"}, hif.bit_index, 4'd0);
      check({tag, "_response"}, hif.response, 8'h00);
      check({tag, "_challenge_out"}, challenge_out, 8'h00);
   endtask

   // Behavioural arbiter: answers arb_lat cycles into each race unless silent.
   initial begin
      int   go_cycles = 0;
      int   idx       = 0;
      logic go_prev   = 1'b0;
      bit_done = 1'b0;
      bit_in   = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         if (go_prev && !race_go && idx == len_check_idx)
            check("race_len", 64'(go_cycles), 64'(TIMEOUT));
         if (race_go && !go_prev) begin
            idx       = int'(hif.bit_index);
            go_cycles = 0;
         end
         go_prev = race_go;
         if (spur_cycles > 0) begin
            bit_done = 1'b1;
            bit_in   = 1'b1;
            spur_cycles--;
         end else if (race_reset) begin
            bit_done = 1'b0;
         end else if (race_go) begin
            go_cycles++;
            if (go_cycles == arb_lat[idx] && idx != silent_race) begin
               bit_in   = arb_bits[7-idx];
               bit_done = 1'b1;
            end
         end
      end
   end

   // Monitor: compares challenge_out at each race start and the response word on resp_valid.
   initial begin
      logic go_prev  = 1'b0;
      logic vld_prev = 1'b0;
      exp_t e;
      logic [7:0] c;
      forever begin
         @(posedge clock);
         #2;
         if (race_go === 1'b1 && !go_prev) begin
            if (chal_q.size() == 0) begin
               check("chal_unexpected_race", 1'b1, 1'b0);
            end else begin
               c = chal_q.pop_front();
               check("challenge_out", challenge_out, c);
            end
         end
         if (hif.resp_valid === 1'b1 && !vld_prev) begin
            if (resp_q.size() == 0) begin
               check("resp_unexpected", hif.response, 8'h00);
            end else begin
               e = resp_q.pop_front();
               check("response", hif.response, e.resp);
               check("timeout_err", hif.timeout_err, e.err);
            end
         end
         go_prev  = (race_go === 1'b1);
         vld_prev = (hif.resp_valid === 1'b1);
      end
   end

   initial begin
      chal_tab_t nom_chal  = '{8'h3C, 8'h3D, 8'h3E, 8'h3F, 8'h40, 8'h41, 8'h42, 8'h43};
      chal_tab_t wrap_chal = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      logic stable;
      int   n;

      hif.start        = 1'b0;
      hif.challenge_in = '0;
      hif.host_ack     = 1'b0;
      setup_arb(8'h00, -1, -1, 0);
      tick(3);
      check_reset_vals("por");
      reset = 1'b0;
      tick(2);

      // Nominal response with start-to-race_go timing.
      setup_arb(8'hB2, -1, -1, 0);
      push_chal_tab(nom_chal);
      resp_q.push_back('{8'hB2, 1'b0});
      start_response(8'h3C);
      check("start_busy", hif.busy, 1'b1);
      check("start_no_go", race_go, 1'b0);
      tick(SETTLE - 1);
      check("settle_last_no_go", race_go, 1'b0);
      tick(1);
      check("settle_go", race_go, 1'b1);
      wait_valid("nominal_valid");
      tick(2);
      ack();

      // Timeout on race 3.
      setup_arb(8'hFF, 3, -1, 0);
      len_check_idx = 3;
      push_chal_base(8'h10);
      resp_q.push_back('{8'hEF, 1'b1});
      start_response(8'h10);
      wait_valid("timeout_valid");
      len_check_idx = -1;
      ack();

      // Challenge wraparound.
      setup_arb(8'h5A, -1, -1, 0);
      push_chal_tab(wrap_chal);
      resp_q.push_back('{8'h5A, 1'b0});
      start_response(8'hFE);
      wait_valid("wrap_valid");
      ack();

      // Handshake hold, ignored start in DONE, immediate restart after ack.
      setup_arb(8'h96, -1, -1, 0);
      push_chal_base(8'h20);
      resp_q.push_back('{8'h96, 1'b0});
      start_response(8'h20);
      wait_valid("hs_valid");
      stable = 1'b1;
      for (int i = 0; i < 50; i++) begin
         hif.start        = (i == 10);
         hif.challenge_in = 8'h77;
         tick(1);
         if (hif.resp_valid !== 1'b1 || hif.response !== 8'h96) stable = 1'b0;
      end
      hif.start = 1'b0;
      check("hs_hold_stable", stable, 1'b1);
      setup_arb(8'h0F, -1, -1, 0);
      push_chal_base(8'h30);
      resp_q.push_back('{8'h0F, 1'b0});
      ack();
      check("ack_valid_low", hif.resp_valid, 1'b0);
      check("ack_idle", hif.busy, 1'b0);
      start_response(8'h30);
      check("restart_accept", hif.busy, 1'b1);
      wait_valid("restart_valid");
      ack();

      // Reset during race 4.
      setup_arb(8'hFF, -1, -1, 0);
      push_chal_base(8'h50);
      resp_q.push_back('{8'hFF, 1'b0});
      start_response(8'h50);
      n = 0;
      while (!(race_go === 1'b1 && hif.bit_index == 4'd4) && n < 500) begin
         tick(1);
         n++;
      end
      check("reach_race4", race_go, 1'b1);
      reset = 1'b1;
      tick(1);
      chal_q.delete();
      resp_q.delete();
      check_reset_vals("mid");
      tick(1);
      reset = 1'b0;
      tick(2);

      // Spurious bit_done while idle.
      spur_cycles = 3;
      tick(10);
      check("spur_response", hif.response, 8'h00);
      check("spur_valid", hif.resp_valid, 1'b0);
      check("spur_busy", hif.busy, 1'b0);

      // Edge lands in the very cycle the timeout expires: real bit wins.
      setup_arb(8'hFF, -1, 0, TIMEOUT - 3);
      push_chal_base(8'h60);
      resp_q.push_back('{8'hFF, 1'b0});
      start_response(8'h60);
      wait_valid("boundary_valid");
      ack();

      tick(5);
      check("resp_sb_drained", 64'(resp_q.size()), 64'd0);
      check("chal_sb_drained", 64'(chal_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
